// File: rtl/commit_monitor_if.sv
// Commit/halt monitor bus: core-side strobes and the retirement order/status
// outputs that feed the RVFI harness.
interface commit_monitor_if #(
    parameter int NRET    = 2,
    parameter int ORDER_W = 64,
    parameter int CNT_W   = 32
);
    logic                      clear_i;
    logic [NRET-1:0]           commit_i;
    logic                      halt_cond_i;
    logic [NRET*ORDER_W-1:0]   order_o;
    logic [CNT_W-1:0]          retired_o;
    logic                      halt_o;
    logic                      timeout_o;
    logic                      late_commit_o;

    modport master (
        output clear_i, commit_i, halt_cond_i,
        input  order_o, retired_o, halt_o, timeout_o, late_commit_o
    );

    modport slave (
        input  clear_i, commit_i, halt_cond_i,
        output order_o, retired_o, halt_o, timeout_o, late_commit_o
    );
endinterface

// File: rtl/commit_monitor.sv
// Assigns retirement order to up to NRET commits per cycle, counts retired
// instructions and raises sticky halt, starvation and late-commit flags.
module commit_monitor #(
    parameter int NRET        = 2,
    parameter int ORDER_W     = 64,
    parameter int CNT_W       = 32,
    parameter int HALT_CYCLES = 2,
    parameter int TIMEOUT     = 10000
) (
    input  logic              clk,
    input  logic              rst,
    commit_monitor_if.slave   mon
);
    localparam int CW     = $clog2(NRET + 1);
    localparam int HC_W   = $clog2(HALT_CYCLES + 1);
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SUM_W  = ((CNT_W > CW) ? CNT_W : CW) + 1;

    logic [ORDER_W-1:0]        base_r;
    logic [CNT_W-1:0]          retired_r;
    logic [HC_W-1:0]           hcnt_r;
    logic [IDLE_W-1:0]         idle_r;
    logic                      halt_r;
    logic                      timeout_r;
    logic                      late_r;

    logic [ORDER_W-1:0]        base_s;
    logic [CNT_W-1:0]          retired_s;
    logic [HC_W-1:0]           hcnt_s;
    logic [IDLE_W-1:0]         idle_s;
    logic                      halt_s;
    logic                      timeout_s;
    logic                      late_s;

    logic [NRET:0][CW-1:0]     prefix_s;
    logic [CW-1:0]             n_s;
    logic [SUM_W-1:0]          sum_s;
    logic [NRET*ORDER_W-1:0]   order_s;

    // Running popcount: prefix_s[i] counts commits in lanes older than lane i.
    always_comb begin
        prefix_s[0] = '0;
        for (int i = 0; i < NRET; i++) begin
            prefix_s[i+1] = prefix_s[i] + CW'(mon.commit_i[i]);
        end
        n_s = prefix_s[NRET];
    end

    // Zero-latency order per lane, valid for idle lanes as well.
    always_comb begin
        order_s = '0;
        for (int i = 0; i < NRET; i++) begin
            order_s[i*ORDER_W +: ORDER_W] = base_r + ORDER_W'(prefix_s[i]);
        end
    end

    // Next-state: clear beats normal update and discards same-cycle commits.
    always_comb begin
        base_s    = base_r;
        retired_s = retired_r;
        hcnt_s    = hcnt_r;
        idle_s    = idle_r;
        halt_s    = halt_r;
        timeout_s = timeout_r;
        late_s    = late_r;
        sum_s     = SUM_W'(retired_r) + SUM_W'(n_s);

        if (mon.clear_i) begin
            base_s    = '0;
            retired_s = '0;
            hcnt_s    = '0;
            idle_s    = '0;
            halt_s    = 1'b0;
            timeout_s = 1'b0;
            late_s    = 1'b0;
        end else begin
            base_s = base_r + ORDER_W'(n_s);

            if (|sum_s[SUM_W-1:CNT_W]) begin
                retired_s = '1;
            end else begin
                retired_s = sum_s[CNT_W-1:0];
            end

            if (mon.halt_cond_i) begin
                if (hcnt_r >= HC_W'(HALT_CYCLES)) begin
                    hcnt_s = hcnt_r;
                end else begin
                    hcnt_s = hcnt_r + HC_W'(1);
                end
                if (hcnt_r >= HC_W'(HALT_CYCLES - 1)) begin
                    halt_s = 1'b1;
                end else begin
                    halt_s = halt_r;
                end
            end else begin
                hcnt_s = '0;
                halt_s = halt_r;
            end

            // A zero TIMEOUT parks the watchdog permanently.
            if (TIMEOUT == 0) begin
                idle_s    = '0;
                timeout_s = 1'b0;
            end else if (n_s != '0) begin
                idle_s    = '0;
                timeout_s = timeout_r;
            end else begin
                if (idle_r >= IDLE_W'(TIMEOUT)) begin
                    idle_s = idle_r;
                end else begin
                    idle_s = idle_r + IDLE_W'(1);
                end
                if (idle_r >= IDLE_W'(TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                end else begin
                    timeout_s = timeout_r;
                end
            end

            if (halt_r && (n_s != '0)) begin
                late_s = 1'b1;
            end else begin
                late_s = late_r;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_r    <= '0;
            retired_r <= '0;
            hcnt_r    <= '0;
            idle_r    <= '0;
            halt_r    <= 1'b0;
            timeout_r <= 1'b0;
            late_r    <= 1'b0;
        end else begin
            base_r    <= base_s;
            retired_r <= retired_s;
            hcnt_r    <= hcnt_s;
            idle_r    <= idle_s;
            halt_r    <= halt_s;
            timeout_r <= timeout_s;
            late_r    <= late_s;
        end
    end

    assign mon.order_o       = order_s;
    assign mon.retired_o     = retired_r;
    assign mon.halt_o        = halt_r;
    assign mon.timeout_o     = timeout_r;
    assign mon.late_commit_o = late_r;
endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench: u0 is a narrow-counter build (wrap/saturation/watchdog),
// u1 runs the same stimulus with HALT_CYCLES=1 and the watchdog disabled.
module tb_commit_monitor;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    commit_monitor_if #(.NRET(2), .ORDER_W(4), .CNT_W(3)) if0 ();
    commit_monitor_if #(.NRET(2), .ORDER_W(8), .CNT_W(8)) if1 ();

    commit_monitor #(.NRET(2), .ORDER_W(4), .CNT_W(3), .HALT_CYCLES(2), .TIMEOUT(4))
        u0 (.clk(clk), .rst(rst), .mon(if0.slave));
    commit_monitor #(.NRET(2), .ORDER_W(8), .CNT_W(8), .HALT_CYCLES(1), .TIMEOUT(0))
        u1 (.clk(clk), .rst(rst), .mon(if1.slave));

    assign if1.clear_i     = if0.clear_i;
    assign if1.commit_i    = if0.commit_i;
    assign if1.halt_cond_i = if0.halt_cond_i;

    logic [3:0] a_l0, a_l1;
    logic [7:0] b_l0, b_l1;
    assign a_l0 = if0.order_o[3:0];
    assign a_l1 = if0.order_o[7:4];
    assign b_l0 = if1.order_o[7:0];
    assign b_l1 = if1.order_o[15:8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        if0.clear_i = 1'b1; if0.commit_i = 2'b00; if0.halt_cond_i = 1'b0;
        tick();
        if0.clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; if0.clear_i = 1'b0; if0.commit_i = 2'b00; if0.halt_cond_i = 1'b0;
        #2;
        tests_run++; if (if0.order_o !== 8'd0) begin tests_failed++; $display("FAIL reset_order got %0h exp 0", if0.order_o); end
        tests_run++; if (if0.retired_o !== 3'd0) begin tests_failed++; $display("FAIL reset_retired got %0d exp 0", if0.retired_o); end
        tests_run++; if ({if0.halt_o, if0.timeout_o, if0.late_commit_o} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b exp 000", {if0.halt_o, if0.timeout_o, if0.late_commit_o}); end
        tests_run++; if (if1.retired_o !== 8'd0) begin tests_failed++; $display("FAIL reset_retired_u1 got %0d exp 0", if1.retired_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_lane();
        do_clear();
        for (int k = 0; k < 5; k++) begin
            if0.commit_i = 2'b01;
            #1;
            tests_run++; if (a_l0 !== 4'(k)) begin tests_failed++; $display("FAIL single_l0 cyc%0d got %0d exp %0d", k, a_l0, k); end
            tests_run++; if (b_l1 !== 8'(k + 1)) begin tests_failed++; $display("FAIL single_l1_u1 cyc%0d got %0d exp %0d", k, b_l1, k + 1); end
            tick();
        end
        if0.commit_i = 2'b00;
        tests_run++; if (if0.retired_o !== 3'd5) begin tests_failed++; $display("FAIL single_retired got %0d exp 5", if0.retired_o); end
        tests_run++; if (if1.retired_o !== 8'd5) begin tests_failed++; $display("FAIL single_retired_u1 got %0d exp 5", if1.retired_o); end
    endtask

    task automatic test_dual_gapped();
        do_clear();
        if0.commit_i = 2'b11; tick(); tick(); tick();
        if0.commit_i = 2'b01; tick();
        if0.commit_i = 2'b11; #1;
        tests_run++; if ({a_l1, a_l0} !== {4'd8, 4'd7}) begin tests_failed++; $display("FAIL dual_lanes got %0d/%0d exp 7/8", a_l0, a_l1); end
        tick();
        if0.commit_i = 2'b10; #1;
        tests_run++; if (a_l1 !== 4'd9) begin tests_failed++; $display("FAIL gapped_l1 got %0d exp 9", a_l1); end
        tests_run++; if (b_l0 !== 8'd9) begin tests_failed++; $display("FAIL gapped_l0_u1 got %0d exp 9", b_l0); end
        tick();
        if0.commit_i = 2'b00; #1;
        tests_run++; if (a_l0 !== 4'd10) begin tests_failed++; $display("FAIL gapped_base got %0d exp 10", a_l0); end
        tests_run++; if (if0.retired_o !== 3'd7) begin tests_failed++; $display("FAIL dual_retired_sat got %0d exp 7", if0.retired_o); end
        tests_run++; if (if1.retired_o !== 8'd10) begin tests_failed++; $display("FAIL dual_retired_u1 got %0d exp 10", if1.retired_o); end
    endtask

    task automatic test_halt();
        logic [3:0] pat;
        logic [3:0] exp0;
        pat  = 4'b1101;
        exp0 = 4'b1000;
        do_clear();
        for (int k = 0; k < 4; k++) begin
            if0.halt_cond_i = pat[k];
            tick();
            tests_run++; if (if0.halt_o !== exp0[k]) begin tests_failed++; $display("FAIL halt_dwell step%0d got %b exp %b", k, if0.halt_o, exp0[k]); end
            if (k == 0) begin
                tests_run++; if (if1.halt_o !== 1'b1) begin tests_failed++; $display("FAIL halt_single_u1 got %b exp 1", if1.halt_o); end
            end
        end
        if0.halt_cond_i = 1'b0;
        tick();
        tests_run++; if (if0.halt_o !== 1'b1) begin tests_failed++; $display("FAIL halt_sticky got %b exp 1", if0.halt_o); end
        tests_run++; if (if0.late_commit_o !== 1'b0) begin tests_failed++; $display("FAIL late_early got %b exp 0", if0.late_commit_o); end
        if0.commit_i = 2'b01;
        tick();
        if0.commit_i = 2'b00; #1;
        tests_run++; if (if0.late_commit_o !== 1'b1) begin tests_failed++; $display("FAIL late_commit got %b exp 1", if0.late_commit_o); end
        tests_run++; if (if1.late_commit_o !== 1'b1) begin tests_failed++; $display("FAIL late_commit_u1 got %b exp 1", if1.late_commit_o); end
        tests_run++; if (a_l0 !== 4'd1) begin tests_failed++; $display("FAIL order_after_halt got %0d exp 1", a_l0); end
    endtask

    task automatic test_wrap_saturate();
        logic [3:0] e;
        do_clear();
        for (int k = 0; k < 9; k++) begin
            if0.commit_i = 2'b11; #1;
            e = 4'(2 * k);
            tests_run++; if (a_l0 !== e) begin tests_failed++; $display("FAIL wrap_l0 cyc%0d got %0d exp %0d", k, a_l0, e); end
            tick();
        end
        if0.commit_i = 2'b00; #1;
        tests_run++; if (a_l0 !== 4'd2) begin tests_failed++; $display("FAIL wrap_base got %0d exp 2", a_l0); end
        tests_run++; if (if0.retired_o !== 3'd7) begin tests_failed++; $display("FAIL sat_retired got %0d exp 7", if0.retired_o); end
        tests_run++; if (if1.retired_o !== 8'd18) begin tests_failed++; $display("FAIL retired_u1 got %0d exp 18", if1.retired_o); end
    endtask

    task automatic test_watchdog();
        do_clear();
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++; if (if0.timeout_o !== 1'b0) begin tests_failed++; $display("FAIL wd_pre idle%0d got %b exp 0", k, if0.timeout_o); end
        end
        if0.commit_i = 2'b01; tick(); if0.commit_i = 2'b00;
        tests_run++; if (if0.timeout_o !== 1'b0) begin tests_failed++; $display("FAIL wd_commit got %b exp 0", if0.timeout_o); end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++; if (if0.timeout_o !== (k == 3)) begin tests_failed++; $display("FAIL wd_idle%0d got %b exp %b", k, if0.timeout_o, (k == 3)); end
        end
        tests_run++; if (if1.timeout_o !== 1'b0) begin tests_failed++; $display("FAIL wd_disabled_u1 got %b exp 0", if1.timeout_o); end
    endtask

    task automatic test_clear_reset();
        do_clear();
        if0.commit_i = 2'b11; tick(); tick();
        #1;
        tests_run++; if (a_l0 !== 4'd4) begin tests_failed++; $display("FAIL pre_clear_base got %0d exp 4", a_l0); end
        if0.clear_i = 1'b1; tick();
        if0.clear_i = 1'b0; if0.commit_i = 2'b00; #1;
        tests_run++; if ({a_l1, a_l0} !== 8'd0) begin tests_failed++; $display("FAIL clear_order got %0h exp 0", {a_l1, a_l0}); end
        tests_run++; if (if0.retired_o !== 3'd0) begin tests_failed++; $display("FAIL clear_retired got %0d exp 0", if0.retired_o); end
        tests_run++; if (if1.retired_o !== 8'd0) begin tests_failed++; $display("FAIL clear_retired_u1 got %0d exp 0", if1.retired_o); end
        if0.commit_i = 2'b11; if0.halt_cond_i = 1'b1;
        tick(); tick(); tick();
        tests_run++; if ({if0.halt_o, if0.late_commit_o} !== 2'b11) begin tests_failed++; $display("FAIL pre_rst_flags got %b exp 11", {if0.halt_o, if0.late_commit_o}); end
        tests_run++; if (if0.retired_o !== 3'd6) begin tests_failed++; $display("FAIL pre_rst_retired got %0d exp 6", if0.retired_o); end
        if0.commit_i = 2'b00; if0.halt_cond_i = 1'b0;
        #2; rst = 1'b0; #1;
        tests_run++; if (if0.order_o !== 8'd0) begin tests_failed++; $display("FAIL async_order got %0h exp 0", if0.order_o); end
        tests_run++; if (if0.retired_o !== 3'd0) begin tests_failed++; $display("FAIL async_retired got %0d exp 0", if0.retired_o); end
        tests_run++; if ({if0.halt_o, if0.timeout_o, if0.late_commit_o} !== 3'b000) begin tests_failed++; $display("FAIL async_flags got %b exp 000", {if0.halt_o, if0.timeout_o, if0.late_commit_o}); end
        tests_run++; if ({if1.halt_o, if1.late_commit_o} !== 2'b00) begin tests_failed++; $display("FAIL async_flags_u1 got %b exp 00", {if1.halt_o, if1.late_commit_o}); end
        #1; rst = 1'b1;
        if0.commit_i = 2'b01; tick(); if0.commit_i = 2'b00;
        tests_run++; if (if0.retired_o !== 3'd1) begin tests_failed++; $display("FAIL post_rst_retired got %0d exp 1", if0.retired_o); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_lane();
        test_dual_gapped();
        test_halt();
        test_wrap_saturate();
        test_watchdog();
        test_clear_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/commit_monitor.md
# commit_monitor

Parametrised commit/halt monitor for the multi-issue successor of the mp4 core. Sits between the core's writeback lanes and the RVFI monitor/shadow-memory harness. Assigns a monotonically increasing retirement order to up to NRET commits per cycle and detects the halt (self-loop) condition after a configurable dwell. Also flags commit starvation and commits that occur after halt.

## Interface
- NRET, 2, commit lanes per cycle (1..8); lane 0 is oldest
- ORDER_W, 64, width of the order counter
- CNT_W, 32, width of the retired-instruction counter
- HALT_CYCLES, 2, consecutive sampled-high cycles of halt_cond_i required to declare halt (>=1)
- TIMEOUT, 10000, idle cycles with no commit before timeout_o; 0 disables
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clear_i  in  1  synchronous clear of all state, same values as reset
- commit_i  in  NRET  per-lane commit strobe; any bit pattern legal
- halt_cond_i  in  1  core's halt condition (branch-to-self detected)
- order_o  out  NRET*ORDER_W  lane i order in bits [i*ORDER_W +: ORDER_W]
- retired_o  out  CNT_W  total commits since reset/clear
- halt_o  out  1  sticky halt indication
- timeout_o  out  1  sticky starvation indication
- late_commit_o  out  1  sticky: a commit was seen while halt_o was high

## Operation
- State: base (ORDER_W), retired (CNT_W), hcnt (ceil(log2(HALT_CYCLES+1)) bits), idle (ceil(log2(TIMEOUT+1)) bits), plus the three sticky flags.
- Reset/clear values: base=0, retired=0, hcnt=0, idle=0, halt_o=0, timeout_o=0, late_commit_o=0. order_o then equals 0 for every lane.
- Order assignment, combinational: order_o[lane i] = base + popcount(commit_i[i-1:0]), modulo 2^ORDER_W. This value is defined for non-committing lanes too; consumers ignore it.
- Commit count n = popcount(commit_i).
  - base <= base + n, wrapping modulo 2^ORDER_W.
  - retired <= retired + n, saturating at 2^CNT_W-1.
- Halt dwell:
  - If halt_cond_i is high, hcnt <= min(hcnt+1, HALT_CYCLES).
  - If halt_cond_i is low, hcnt <= 0.
  - halt_o <= 1 on the edge where hcnt+1 reaches HALT_CYCLES.
  - Once set, halt_o holds until reset or clear, even if halt_cond_i drops.
- Idle watchdog (TIMEOUT>0):
  - On any commit, idle <= 0.
  - Otherwise idle <= min(idle+1, TIMEOUT).
  - timeout_o <= 1 on the edge where idle+1 reaches TIMEOUT. It is sticky.
- Late commit: if halt_o=1 and n>0 at an edge, late_commit_o <= 1 (sticky). Orders and retired continue to advance after halt.
- Precedence within one edge: rst (async) > clear_i > normal update. A commit presented in a clear cycle is discarded: it does not affect base or retired.

## Timing
- order_o is combinational from commit_i and registered base: zero latency, valid in the same cycle as the commit.
- retired_o and all flags are registered and reflect events one edge later.
- halt_o rises at the end of the HALT_CYCLES-th consecutive high cycle of halt_cond_i.
  - HALT_CYCLES=1: halt_o high the cycle after the first high sample.
- timeout_o rises after exactly TIMEOUT consecutive commit-free edges.
- Reset asserted mid-run clears all state immediately, without waiting for clk. Normal operation resumes on the first rising edge after rst returns high.
- No handshake: commit_i is sampled every cycle; there is no backpressure.

## Test plan
- Single-lane counting:
  - Stimulus: NRET=2, commit_i=2'b01 for 5 cycles.
  - Required: order_o lane0 reads 0,1,2,3,4 in those cycles; retired_o=5 afterwards.
- Dual commit and gapped lanes:
  - Stimulus: base=7, then commit_i=2'b11.
  - Required: lane0=7, lane1=8, base becomes 9.
  - Stimulus: next cycle commit_i=2'b10.
  - Required: lane1=9, base becomes 10.
- Halt dwell (HALT_CYCLES=2):
  - Stimulus: halt_cond_i pattern 1,0,1,1.
  - Required: halt_o stays 0 through the 1,0 pair; it rises after the second consecutive 1 and stays high after halt_cond_i drops.
  - Stimulus: a subsequent commit.
  - Required: late_commit_o=1.
- Wrap and saturation:
  - Stimulus: ORDER_W=4, CNT_W=3, commit_i=2'b11 for 9 cycles.
  - Required: base wraps 14 -> 0; retired_o sticks at 7.
- Watchdog (TIMEOUT=4):
  - Stimulus: 3 idle cycles, then 1 commit, then 4 idle cycles.
  - Required: timeout_o stays 0 until after the 4th consecutive idle edge, then goes to 1.
- Clear versus reset:
  - Stimulus: clear_i=1 together with commit_i=2'b11.
  - Required: base=0 and retired_o=0 next cycle.
  - Stimulus: drop rst low asynchronously mid-cycle.
  - Required: all outputs go to 0 before the next edge.
